// File: rtl/udp_port_filter.sv
// udp_port_filter
//
// Sits on the RX side of the UDP block and forwards only frames whose UDP
// destination port matches cfg_port; all other frames are swallowed.
// The header is registered (one cycle from accept to m_udp_hdr_valid).
// The payload is a zero-latency combinational pass-through while forwarding.
// Dropped payload is consumed internally up to and including tlast.
// At most one frame is in flight: a new header is refused until the previous
// payload has ended and the previous output header has been taken.
//
// Optional feature (macro UDP_PORT_FILTER_STATS_EN):
//   defined     -> stat_match_count / stat_drop_count are wrapping frame counters
//   not defined -> no counter flops, both statistics outputs tied to 0
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cfg_enable, cfg_port           filter control, sampled only at header accept
//   s_udp_hdr_* / s_udp_ip_* / s_udp_*_port / s_udp_length   input header
//   s_udp_payload_axis_*           input payload stream (tready is an output)
//   m_udp_hdr_* / m_udp_ip_* / m_udp_*_port / m_udp_length   registered output header
//   m_udp_payload_axis_*           output payload stream (tready is an input)
//   stat_match_count, stat_drop_count   forwarded / dropped frame counts

module udp_port_filter #(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter bit          MATCH_ANY_ZERO = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   cfg_enable,
  input  logic [15:0]            cfg_port,

  input  logic                   s_udp_hdr_valid,
  output logic                   s_udp_hdr_ready,
  input  logic [31:0]            s_udp_ip_source_ip,
  input  logic [31:0]            s_udp_ip_dest_ip,
  input  logic [15:0]            s_udp_source_port,
  input  logic [15:0]            s_udp_dest_port,
  input  logic [15:0]            s_udp_length,
  input  logic [7:0]             s_udp_payload_axis_tdata,
  input  logic                   s_udp_payload_axis_tvalid,
  output logic                   s_udp_payload_axis_tready,
  input  logic                   s_udp_payload_axis_tlast,
  input  logic                   s_udp_payload_axis_tuser,

  output logic                   m_udp_hdr_valid,
  input  logic                   m_udp_hdr_ready,
  output logic [31:0]            m_udp_ip_source_ip,
  output logic [31:0]            m_udp_ip_dest_ip,
  output logic [15:0]            m_udp_source_port,
  output logic [15:0]            m_udp_dest_port,
  output logic [15:0]            m_udp_length,
  output logic [7:0]             m_udp_payload_axis_tdata,
  output logic                   m_udp_payload_axis_tvalid,
  input  logic                   m_udp_payload_axis_tready,
  output logic                   m_udp_payload_axis_tlast,
  output logic                   m_udp_payload_axis_tuser,

  output logic [COUNT_WIDTH-1:0] stat_match_count,
  output logic [COUNT_WIDTH-1:0] stat_drop_count
);

  typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

  state_e      state_q, state_d;
  logic        hdr_valid_q;
  logic [31:0] src_ip_q, dst_ip_q;
  logic [15:0] src_port_q, dst_port_q, length_q;

  logic hdr_accept;
  logic port_match;

  // cfg_port == 0 acts as a wildcard only when MATCH_ANY_ZERO is set.
  assign port_match = cfg_enable &&
                      ((s_udp_dest_port == cfg_port) || (MATCH_ANY_ZERO && (cfg_port == 16'd0)));
  assign hdr_accept = s_udp_hdr_valid && s_udp_hdr_ready;

  // Data, last and user are passed straight through; only tvalid is gated.
  assign m_udp_payload_axis_tdata = s_udp_payload_axis_tdata;
  assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast;
  assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser;

  always_comb begin
    state_d                   = state_q;
    // rst_n gating keeps header ready low while reset is held.
    s_udp_hdr_ready           = 1'b0;
    s_udp_payload_axis_tready = 1'b0;
    m_udp_payload_axis_tvalid = 1'b0;
    unique case (state_q)
      StIdle: begin
        s_udp_hdr_ready = rst_n && !hdr_valid_q;
        if (hdr_accept) begin
          state_d = port_match ? StFwd : StDrop;
        end
      end
      StFwd: begin
        m_udp_payload_axis_tvalid = s_udp_payload_axis_tvalid;
        s_udp_payload_axis_tready = m_udp_payload_axis_tready;
        if (s_udp_payload_axis_tvalid && m_udp_payload_axis_tready && s_udp_payload_axis_tlast) begin
          state_d = StIdle;
        end
      end
      StDrop: begin
        s_udp_payload_axis_tready = 1'b1;
        if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hdr_valid_q <= 1'b0;
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      src_port_q  <= '0;
      dst_port_q  <= '0;
      length_q    <= '0;
    end else begin
      state_q <= state_d;
      // A header can only be accepted while hdr_valid_q is low, so the
      // load and the clear never coincide.
      if (hdr_accept && port_match) begin
        hdr_valid_q <= 1'b1;
        src_ip_q    <= s_udp_ip_source_ip;
        dst_ip_q    <= s_udp_ip_dest_ip;
        src_port_q  <= s_udp_source_port;
        dst_port_q  <= s_udp_dest_port;
        length_q    <= s_udp_length;
      end else if (m_udp_hdr_ready) begin
        hdr_valid_q <= 1'b0;
      end
    end
  end

  assign m_udp_hdr_valid    = hdr_valid_q;
  assign m_udp_ip_source_ip = src_ip_q;
  assign m_udp_ip_dest_ip   = dst_ip_q;
  assign m_udp_source_port  = src_port_q;
  assign m_udp_dest_port    = dst_port_q;
  assign m_udp_length       = length_q;

`ifdef UDP_PORT_FILTER_STATS_EN
  logic [COUNT_WIDTH-1:0] stat_match_q, stat_drop_q;
  logic                   fwd_done, drop_done;

  assign fwd_done  = (state_q == StFwd) && s_udp_payload_axis_tvalid &&
                     m_udp_payload_axis_tready && s_udp_payload_axis_tlast;
  assign drop_done = (state_q == StDrop) && s_udp_payload_axis_tvalid &&
                     s_udp_payload_axis_tlast;

  // Counters wrap naturally from all-ones to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_match_q <= '0;
      stat_drop_q  <= '0;
    end else begin
      if (fwd_done)  stat_match_q <= stat_match_q + 1'b1;
      if (drop_done) stat_drop_q  <= stat_drop_q + 1'b1;
    end
  end

  assign stat_match_count = stat_match_q;
  assign stat_drop_count  = stat_drop_q;
`else
  assign stat_match_count = '0;
  assign stat_drop_count  = '0;
`endif

endmodule

// File: tb/tb_udp_port_filter.sv
// Directed self-checking bench for udp_port_filter.
module tb_udp_port_filter;

  localparam int unsigned CW = 32;
`ifdef UDP_PORT_FILTER_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_enable;
  logic [15:0]   cfg_port;
  logic          s_hdr_valid, s_hdr_ready;
  logic [31:0]   s_src_ip, s_dst_ip;
  logic [15:0]   s_src_port, s_dst_port, s_length;
  logic [7:0]    s_tdata;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic          m_hdr_valid, m_hdr_ready;
  logic [31:0]   m_src_ip, m_dst_ip;
  logic [15:0]   m_src_port, m_dst_port, m_length;
  logic [7:0]    m_tdata;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic [CW-1:0] stat_match, stat_drop;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [CW-1:0] exp_match = '0;
  logic [CW-1:0] exp_drop  = '0;

  always #5 clk = ~clk;

  udp_port_filter #(
    .COUNT_WIDTH   (CW),
    .MATCH_ANY_ZERO(1'b1)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .cfg_enable               (cfg_enable),
    .cfg_port                 (cfg_port),
    .s_udp_hdr_valid          (s_hdr_valid),
    .s_udp_hdr_ready          (s_hdr_ready),
    .s_udp_ip_source_ip       (s_src_ip),
    .s_udp_ip_dest_ip         (s_dst_ip),
    .s_udp_source_port        (s_src_port),
    .s_udp_dest_port          (s_dst_port),
    .s_udp_length             (s_length),
    .s_udp_payload_axis_tdata (s_tdata),
    .s_udp_payload_axis_tvalid(s_tvalid),
    .s_udp_payload_axis_tready(s_tready),
    .s_udp_payload_axis_tlast (s_tlast),
    .s_udp_payload_axis_tuser (s_tuser),
    .m_udp_hdr_valid          (m_hdr_valid),
    .m_udp_hdr_ready          (m_hdr_ready),
    .m_udp_ip_source_ip       (m_src_ip),
    .m_udp_ip_dest_ip         (m_dst_ip),
    .m_udp_source_port        (m_src_port),
    .m_udp_dest_port          (m_dst_port),
    .m_udp_length             (m_length),
    .m_udp_payload_axis_tdata (m_tdata),
    .m_udp_payload_axis_tvalid(m_tvalid),
    .m_udp_payload_axis_tready(m_tready),
    .m_udp_payload_axis_tlast (m_tlast),
    .m_udp_payload_axis_tuser (m_tuser),
    .stat_match_count         (stat_match),
    .stat_drop_count          (stat_drop)
  );

  // Stimulus helpers only: drive, never compare.
  task automatic set_hdr(input logic [15:0] dport, input logic [15:0] len);
    s_src_ip   = 32'hC0A8_0001;
    s_dst_ip   = 32'hC0A8_0002;
    s_src_port = 16'd4000;
    s_dst_port = dport;
    s_length   = len;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a header for exactly one cycle (caller ensures ready is high).
  task automatic push_hdr(input logic [15:0] dport, input logic [15:0] len);
    set_hdr(dport, len);
    s_hdr_valid = 1'b1;
    next_cycle();
    s_hdr_valid = 1'b0;
    set_hdr(16'hFFFF, 16'hFFFF);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (m_hdr_valid !== 1'b0 || s_hdr_ready !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got hv=%b hr=%b tv=%b tr=%b, want 0 0 0 0",
               m_hdr_valid, s_hdr_ready, m_tvalid, s_tready);
    end
    n_tests++;
    if ({m_src_ip, m_dst_ip, m_src_port, m_dst_port, m_length} !== 112'd0 ||
        stat_match !== '0 || stat_drop !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got dport=%0d len=%0d mc=%0d dc=%0d, want all 0",
               m_dst_port, m_length, stat_match, stat_drop);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (s_hdr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", s_hdr_ready);
    end
    next_cycle();
  endtask

  task automatic test_forward();
    cfg_port = 16'd1234; cfg_enable = 1'b1; m_hdr_ready = 1'b0; m_tready = 1'b1;
    push_hdr(16'd1234, 16'd12);
    n_tests++;
    if (m_hdr_valid !== 1'b1 || m_dst_port !== 16'd1234 || m_length !== 16'd12 ||
        m_src_ip !== 32'hC0A8_0001 || m_dst_ip !== 32'hC0A8_0002 || m_src_port !== 16'd4000) begin
      n_fail++;
      $display("FAIL fwd_hdr: got v=%b dport=%0d len=%0d sport=%0d, want 1 1234 12 4000",
               m_hdr_valid, m_dst_port, m_length, m_src_port);
    end
    m_hdr_ready = 1'b1;
    next_cycle();
    m_hdr_ready = 1'b0;
    n_tests++;
    if (m_hdr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_hdr_clear: got %b want 0", m_hdr_valid);
    end
    for (int b = 1; b <= 4; b++) begin
      s_tvalid = 1'b1; s_tdata = 8'(b); s_tlast = (b == 4); s_tuser = (b == 2);
      #1;
      n_tests++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'(b) || m_tlast !== (b == 4) ||
          m_tuser !== (b == 2) || s_tready !== 1'b1) begin
        n_fail++;
        $display("FAIL fwd_beat%0d: got v=%b d=%h l=%b u=%b r=%b, want 1 %h %b %b 1",
                 b, m_tvalid, m_tdata, m_tlast, m_tuser, s_tready, 8'(b), b == 4, b == 2);
      end
      next_cycle();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    if (Stats) exp_match++;
    #1;
    n_tests++;
    if (s_hdr_ready !== 1'b1 || stat_match !== exp_match || stat_drop !== exp_drop) begin
      n_fail++;
      $display("FAIL fwd_end: got hr=%b mc=%0d dc=%0d, want 1 %0d %0d",
               s_hdr_ready, stat_match, stat_drop, exp_match, exp_drop);
    end
  endtask

  task automatic test_drop();
    int bad;
    bad = 0;
    cfg_port = 16'd1234; cfg_enable = 1'b1; m_hdr_ready = 1'b1; m_tready = 1'b0;
    push_hdr(16'd5678, 16'd72);
    for (int b = 0; b < 64; b++) begin
      s_tvalid = 1'b1; s_tdata = 8'(b); s_tlast = (b == 63);
      #1;
      if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || m_hdr_valid !== 1'b0) bad++;
      next_cycle();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (Stats) exp_drop++;
    #1;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL drop_beats: got %0d bad beats of 64, want 0", bad);
    end
    n_tests++;
    if (s_hdr_ready !== 1'b1 || stat_drop !== exp_drop || stat_match !== exp_match) begin
      n_fail++;
      $display("FAIL drop_end: got hr=%b dc=%0d mc=%0d, want 1 %0d %0d",
               s_hdr_ready, stat_drop, stat_match, exp_drop, exp_match);
    end
  endtask

  task automatic test_cfg_modes();
    // Wildcard port 0 forwards any destination.
    cfg_port = 16'd0; cfg_enable = 1'b1; m_hdr_ready = 1'b0; m_tready = 1'b1;
    push_hdr(16'd80, 16'd9);
    cfg_port = 16'd9999; // mid-frame change must not matter
    n_tests++;
    if (m_hdr_valid !== 1'b1 || m_dst_port !== 16'd80) begin
      n_fail++;
      $display("FAIL any_zero_hdr: got v=%b dport=%0d, want 1 80", m_hdr_valid, m_dst_port);
    end
    m_hdr_ready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 8'hA5; s_tlast = 1'b1;
    #1;
    n_tests++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5 || s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL any_zero_beat: got v=%b d=%h r=%b, want 1 a5 1", m_tvalid, m_tdata, s_tready);
    end
    next_cycle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (Stats) exp_match++;
    // Disabled filter drops even an exact match.
    cfg_port = 16'd1234; cfg_enable = 1'b0;
    push_hdr(16'd1234, 16'd9);
    cfg_enable = 1'b1;
    s_tvalid = 1'b1; s_tdata = 8'h5A; s_tlast = 1'b1; m_tready = 1'b0;
    #1;
    n_tests++;
    if (m_hdr_valid !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL disabled_drop: got hv=%b tv=%b tr=%b, want 0 0 1", m_hdr_valid, m_tvalid, s_tready);
    end
    next_cycle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (Stats) exp_drop++;
    #1;
    n_tests++;
    if (stat_match !== exp_match || stat_drop !== exp_drop) begin
      n_fail++;
      $display("FAIL cfg_counts: got mc=%0d dc=%0d, want %0d %0d",
               stat_match, stat_drop, exp_match, exp_drop);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int bad_hdr, bad_flow;
    k = 0; bad_hdr = 0; bad_flow = 0;
    cfg_port = 16'd1234; cfg_enable = 1'b1; m_hdr_ready = 1'b0;
    push_hdr(16'd1234, 16'd12);
    for (int i = 0; i < 10; i++) begin
      m_tready = i[0];
      if (k < 4) begin
        s_tvalid = 1'b1; s_tdata = 8'(8'h10 + k); s_tlast = (k == 3);
      end else begin
        s_tvalid = 1'b0; s_tlast = 1'b0;
        set_hdr(16'd5678, 16'd9);
        s_hdr_valid = 1'b1;
      end
      #1;
      if (m_hdr_valid !== 1'b1 || m_dst_port !== 16'd1234 || m_length !== 16'd12 ||
          m_src_ip !== 32'hC0A8_0001 || s_hdr_ready !== 1'b0) bad_hdr++;
      if (k < 4 && (m_tvalid !== 1'b1 || m_tdata !== 8'(8'h10 + k) || s_tready !== i[0]))
        bad_flow++;
      if (s_tvalid && s_tready) k++;
      next_cycle();
    end
    n_tests++;
    if (bad_hdr != 0) begin
      n_fail++;
      $display("FAIL b2b_hdr_hold: got %0d bad cycles of 10, want 0", bad_hdr);
    end
    n_tests++;
    if (bad_flow != 0 || k != 4) begin
      n_fail++;
      $display("FAIL b2b_flow: got bad=%0d beats=%0d, want 0 4", bad_flow, k);
    end
    if (Stats) exp_match++;
    m_hdr_ready = 1'b1;
    next_cycle();                 // output header handshake; second header still blocked
    n_tests++;
    if (m_hdr_valid !== 1'b0 || s_hdr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_release: got hv=%b hr=%b, want 0 1", m_hdr_valid, s_hdr_ready);
    end
    next_cycle();                 // second (mismatching) header accepted here
    s_hdr_valid = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'hEE; s_tlast = 1'b1; m_tready = 1'b0;
    #1;
    n_tests++;
    if (s_tready !== 1'b1 || m_tvalid !== 1'b0 || m_hdr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_drop: got tr=%b tv=%b hv=%b, want 1 0 0", s_tready, m_tvalid, m_hdr_valid);
    end
    next_cycle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (Stats) exp_drop++;
    #1;
    n_tests++;
    if (stat_match !== exp_match || stat_drop !== exp_drop) begin
      n_fail++;
      $display("FAIL b2b_counts: got mc=%0d dc=%0d, want %0d %0d",
               stat_match, stat_drop, exp_match, exp_drop);
    end
  endtask

  task automatic test_reset_mid_frame();
    cfg_port = 16'd1234; cfg_enable = 1'b1; m_hdr_ready = 1'b0; m_tready = 1'b1;
    push_hdr(16'd1234, 16'd14);
    for (int b = 1; b <= 2; b++) begin
      s_tvalid = 1'b1; s_tdata = 8'(b); s_tlast = 1'b0;
      next_cycle();
    end
    s_tdata = 8'd3;
    #1;
    rst_n = 1'b0;
    #1;
    exp_match = '0; exp_drop = '0;
    n_tests++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0 || m_hdr_valid !== 1'b0 || s_hdr_ready !== 1'b0 ||
        stat_match !== '0 || stat_drop !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got tv=%b tr=%b hv=%b hr=%b mc=%0d dc=%0d, want all 0",
               m_tvalid, s_tready, m_hdr_valid, s_hdr_ready, stat_match, stat_drop);
    end
    s_tvalid = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    m_hdr_ready = 1'b1;
    push_hdr(16'd1234, 16'd9);
    s_tvalid = 1'b1; s_tdata = 8'h77; s_tlast = 1'b1;
    #1;
    n_tests++;
    if (m_hdr_valid !== 1'b1 || m_dst_port !== 16'd1234 || m_tvalid !== 1'b1 ||
        m_tdata !== 8'h77 || m_tlast !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_new_frame: got hv=%b dport=%0d tv=%b d=%h l=%b, want 1 1234 1 77 1",
               m_hdr_valid, m_dst_port, m_tvalid, m_tdata, m_tlast);
    end
    next_cycle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (Stats) exp_match++;
    #1;
    n_tests++;
    if (stat_match !== exp_match || stat_drop !== exp_drop || m_hdr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_counts: got mc=%0d dc=%0d hv=%b, want %0d %0d 0",
               stat_match, stat_drop, m_hdr_valid, exp_match, exp_drop);
    end
  endtask

  task automatic test_counter_wrap();
`ifdef UDP_PORT_FILTER_STATS_EN
    force dut.stat_drop_q = '1;
    #1;
    release dut.stat_drop_q;
    exp_drop = '0;
`endif
    cfg_port = 16'd1234; cfg_enable = 1'b1; m_hdr_ready = 1'b1;
    push_hdr(16'd4321, 16'd9);
    s_tvalid = 1'b1; s_tdata = 8'h01; s_tlast = 1'b1;
    next_cycle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
    n_tests++;
    if (stat_drop !== '0 || stat_match !== exp_match) begin
      n_fail++;
      $display("FAIL counter_wrap: got dc=%0d mc=%0d, want 0 %0d", stat_drop, stat_match, exp_match);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_enable = 1'b0; cfg_port = '0;
    s_hdr_valid = 1'b0; set_hdr(16'd0, 16'd0);
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    m_hdr_ready = 1'b0; m_tready = 1'b0;
    #1;
    test_reset();
    test_forward();
    test_drop();
    test_cfg_modes();
    test_back_to_back();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
